// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad timer-entry path: BCD code width,
// largest legal decimal digit and the key-handling FSM state encoding.
package keypad_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      RELEASE  = 2'd2
   } key_state_t;

   // True when the encoder code is a decimal digit (0..9) rather than a
   // function key or an unused code.
   function automatic logic is_digit(input logic [BCD_W-1:0] code);
      return (code <= BCD_MAX);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchroniser. Each bit is synchronised
// independently; multi-bit coherence is the consumer's job (the digit entry
// FSM re-latches the code whenever it changes during debounce).
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // First flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad digit entry: synchronises and debounces presses from the keypad
// priority encoder and shifts each accepted decimal digit into a BCD digit
// register, newest digit in the least-significant nibble.
//
// Optional build macro DIGIT_ENTRY_FULL_LOCK_EN: when defined, a full
// register ignores further digits until clear or reset. When undefined, a
// full register keeps shifting and the oldest digit falls off the top.
module keypad_digit_entry
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int NUM_DIGITS      = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [BCD_W-1:0]            bcd_in,
   input  logic                        data_val,
   input  logic                        clear,
   output logic [BCD_W*NUM_DIGITS-1:0] digits,
   output logic [2:0]                  digit_count,
   output logic                        full,
   output logic                        digit_strobe,
   output logic                        busy
);

   localparam int               DIGITS_W  = BCD_W * NUM_DIGITS;
   localparam logic [7:0]       CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]       COUNT_MAX = 3'(NUM_DIGITS);

   // Synchronised encoder outputs
   logic [BCD_W:0]       sync_d;
   logic [BCD_W:0]       sync_q;
   logic                 dv_s;
   logic [BCD_W-1:0]     code_s;

   // FSM state and its shared debounce/release counter
   key_state_t           state;
   key_state_t           state_next;
   logic [7:0]           cnt;
   logic [7:0]           cnt_next;
   logic [BCD_W-1:0]     key_code;
   logic [BCD_W-1:0]     key_code_next;
   logic                 accept;

   // Digit register datapath
   logic                 take_digit;
   logic [DIGITS_W-1:0]  digits_shifted;
   logic [2:0]           count_inc;

   assign sync_d = {data_val, bcd_in};

   sync_2ff #(
      .WIDTH (BCD_W + 1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sync_d),
      .q     (sync_q)
   );

   assign dv_s   = sync_q[BCD_W];
   assign code_s = sync_q[BCD_W-1:0];

   // FSM state, counter and latched key code registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         key_code <= '0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         key_code <= key_code_next;
      end
   end

   // Next-state logic: debounce a press, accept once, then wait for a clean
   // release so that a held key yields exactly one digit.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      key_code_next = key_code;
      accept        = 1'b0;
      case (state)
         IDLE: begin
            if (dv_s) begin
               state_next    = DEBOUNCE;
               key_code_next = code_s;
               cnt_next      = '0;
            end
         end
         DEBOUNCE: begin
            if (!dv_s) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (code_s != key_code) begin
               key_code_next = code_s;
               cnt_next      = '0;
            end else if (cnt == CNT_LAST) begin
               accept     = 1'b1;
               state_next = RELEASE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         RELEASE: begin
            if (dv_s) begin
               cnt_next = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Decide whether this accept actually enters a digit and prepare the
   // shifted register and saturating count.
   always_comb begin
`ifdef DIGIT_ENTRY_FULL_LOCK_EN
      take_digit = accept && is_digit(key_code) && !full;
`else
      take_digit = accept && is_digit(key_code);
`endif
      digits_shifted = DIGITS_W'({digits, key_code});
      count_inc      = (digit_count == COUNT_MAX) ? digit_count : digit_count + 3'd1;
   end

   // Registered outputs; clear wins over a same-cycle accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits       <= '0;
         digit_count  <= '0;
         full         <= 1'b0;
         digit_strobe <= 1'b0;
         busy         <= 1'b0;
      end else begin
         busy         <= (state_next != IDLE);
         digit_strobe <= 1'b0;
         if (clear) begin
            digits      <= '0;
            digit_count <= '0;
            full        <= 1'b0;
         end else if (take_digit) begin
            digits       <= digits_shifted;
            digit_count  <= count_inc;
            full         <= (count_inc == COUNT_MAX);
            digit_strobe <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed self-checking bench for keypad_digit_entry with
// DEBOUNCE_CYCLES=4 and NUM_DIGITS=4. Honours DIGIT_ENTRY_FULL_LOCK_EN.
module tb_keypad_digit_entry;

   logic        clk;
   logic        reset;
   logic [3:0]  bcd_in;
   logic        data_val;
   logic        clear;
   logic [15:0] digits;
   logic [2:0]  digit_count;
   logic        full;
   logic        digit_strobe;
   logic        busy;

   int checks;
   int errors;
   int strobe_count;
   int strobe_base;

   keypad_digit_entry #(
      .DEBOUNCE_CYCLES (4),
      .NUM_DIGITS      (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bcd_in       (bcd_in),
      .data_val     (data_val),
      .clear        (clear),
      .digits       (digits),
      .digit_count  (digit_count),
      .full         (full),
      .digit_strobe (digit_strobe),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count strobe pulses mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (digit_strobe === 1'b1) strobe_count <= strobe_count + 1;
   end

   // Advance n rising edges and land 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Press a key for hold cycles, then release and allow the release window.
   task automatic apply_stimulus(input logic [3:0] code, input int hold);
      bcd_in   = code;
      data_val = 1'b1;
      tick(hold);
      data_val = 1'b0;
      tick(10);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      strobe_count = 0;
      reset        = 1'b1;
      bcd_in       = 4'd0;
      data_val     = 1'b0;
      clear        = 1'b0;
      tick(3);

      check_output("reset_digits", 32'(digits), 32'h0);
      check_output("reset_count", 32'(digit_count), 32'd0);
      check_output("reset_full", 32'(full), 32'd0);
      check_output("reset_strobe", 32'(digit_strobe), 32'd0);
      check_output("reset_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick(2);

      // Held key 3: one strobe at edge 7, none afterwards.
      strobe_base = strobe_count;
      bcd_in      = 4'd3;
      data_val    = 1'b1;
      tick(6);
      check_output("hold3_edge6_strobe", 32'(digit_strobe), 32'd0);
      check_output("hold3_edge6_digits", 32'(digits), 32'h0);
      tick(1);
      check_output("hold3_edge7_strobe", 32'(digit_strobe), 32'd1);
      check_output("hold3_edge7_digits", 32'(digits), 32'h0003);
      check_output("hold3_edge7_count", 32'(digit_count), 32'd1);
      check_output("hold3_edge7_busy", 32'(busy), 32'd1);
      tick(1);
      check_output("hold3_edge8_strobe", 32'(digit_strobe), 32'd0);
      tick(12);
      data_val = 1'b0;
      tick(10);
      check_output("hold3_strobes", 32'(strobe_count - strobe_base), 32'd1);
      check_output("hold3_idle_busy", 32'(busy), 32'd0);

      // Clear, then enter 1..5.
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check_output("clear_digits", 32'(digits), 32'h0);
      check_output("clear_count", 32'(digit_count), 32'd0);
      strobe_base = strobe_count;
      apply_stimulus(4'd1, 10);
      apply_stimulus(4'd2, 10);
      apply_stimulus(4'd3, 10);
      apply_stimulus(4'd4, 10);
      check_output("four_digits", 32'(digits), 32'h1234);
      check_output("four_full", 32'(full), 32'd1);
      check_output("four_count", 32'(digit_count), 32'd4);
      apply_stimulus(4'd5, 10);
`ifdef DIGIT_ENTRY_FULL_LOCK_EN
      check_output("five_digits", 32'(digits), 32'h1234);
      check_output("five_strobes", 32'(strobe_count - strobe_base), 32'd4);
`else
      check_output("five_digits", 32'(digits), 32'h2345);
      check_output("five_strobes", 32'(strobe_count - strobe_base), 32'd5);
`endif
      check_output("five_count", 32'(digit_count), 32'd4);
      check_output("five_full", 32'(full), 32'd1);

      // Two-cycle data_val pulse is rejected as a glitch.
      strobe_base = strobe_count;
      bcd_in      = 4'd6;
      data_val    = 1'b1;
      tick(2);
      data_val = 1'b0;
      tick(6);
      check_output("glitch_strobes", 32'(strobe_count - strobe_base), 32'd0);
`ifdef DIGIT_ENTRY_FULL_LOCK_EN
      check_output("glitch_digits", 32'(digits), 32'h1234);
`else
      check_output("glitch_digits", 32'(digits), 32'h2345);
`endif
      check_output("glitch_busy", 32'(busy), 32'd0);

      // Non-digit code 0xF is discarded.
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      apply_stimulus(4'd8, 10);
      strobe_base = strobe_count;
      apply_stimulus(4'hF, 10);
      check_output("code_f_strobes", 32'(strobe_count - strobe_base), 32'd0);
      check_output("code_f_digits", 32'(digits), 32'h0008);
      check_output("code_f_count", 32'(digit_count), 32'd1);

      // Key 7 with a release glitch and a re-hold inside the release window.
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      strobe_base = strobe_count;
      bcd_in      = 4'd7;
      data_val    = 1'b1;
      tick(10);
      data_val = 1'b0;
      tick(3);
      data_val = 1'b1;
      tick(1);
      data_val = 1'b0;
      tick(2);
      data_val = 1'b1;
      tick(8);
      data_val = 1'b0;
      tick(10);
      check_output("bounce7_strobes", 32'(strobe_count - strobe_base), 32'd1);
      check_output("bounce7_digits", 32'(digits), 32'h0007);
      check_output("bounce7_count", 32'(digit_count), 32'd1);

      // clear in the accept cycle wins; held key is not re-accepted.
      strobe_base = strobe_count;
      bcd_in      = 4'd5;
      data_val    = 1'b1;
      tick(6);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check_output("clr_acc_strobe", 32'(digit_strobe), 32'd0);
      check_output("clr_acc_digits", 32'(digits), 32'h0);
      check_output("clr_acc_count", 32'(digit_count), 32'd0);
      tick(5);
      data_val = 1'b0;
      tick(10);
      check_output("clr_acc_strobes", 32'(strobe_count - strobe_base), 32'd0);
      check_output("clr_acc_digits_after", 32'(digits), 32'h0);

      // Reset in the middle of DEBOUNCE, then the still-held key re-enters.
      apply_stimulus(4'd9, 10);
      check_output("pre_reset_digits", 32'(digits), 32'h0009);
      bcd_in   = 4'd8;
      data_val = 1'b1;
      tick(4);
      check_output("mid_deb_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check_output("midrst_digits", 32'(digits), 32'h0);
      check_output("midrst_count", 32'(digit_count), 32'd0);
      check_output("midrst_busy", 32'(busy), 32'd0);
      check_output("midrst_full", 32'(full), 32'd0);
      check_output("midrst_strobe", 32'(digit_strobe), 32'd0);
      reset = 1'b0;
      tick(6);
      check_output("post_rst_edge6_strobe", 32'(digit_strobe), 32'd0);
      tick(1);
      check_output("post_rst_edge7_strobe", 32'(digit_strobe), 32'd1);
      check_output("post_rst_edge7_digits", 32'(digits), 32'h0008);
      check_output("post_rst_edge7_count", 32'(digit_count), 32'd1);
      data_val = 1'b0;
      tick(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
